// File: rtl/injection_arbiter_pkg.sv
// noc_inj_pkg: shared definitions for the injection arbiter slice.
//   - inj_state_e : 2-bit FSM state encodings (IDLE/FWD_REQ/UP_GNT/RELEASE)
//   - NUM_REQ_DEF : default number of injectors
//   - DATA_W_DEF  : default packet flit width
//   - PKT_CNT_W   : width of the forwarded-packet counter
package noc_inj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FWD_REQ = 2'd1,
        ST_UP_GNT  = 2'd2,
        ST_RELEASE = 2'd3
    } inj_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int PKT_CNT_W   = 16;

endpackage

// File: rtl/injection_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req_i         in  NUM_REQ  request vector
//   last_i        in  SEL_W    index of the most recent winner
//   grant_valid_o out 1        at least one request present
//   grant_idx_o   out SEL_W    winner, searching from last_i+1 upward (mod NUM_REQ)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_i,
    output logic               grant_valid_o,
    output logic [SEL_W-1:0]   grant_idx_o
);

    int unsigned idx;

    // Scan offsets from farthest to nearest so the nearest requester after
    // last_i is the one left standing. Offset NUM_REQ wraps to last_i itself,
    // giving the previous winner the lowest priority.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/injection_arbiter.sv
// injection_arbiter: shares one router Local input port among NUM_REQ injectors.
//   clk       in  1                  system clock, rising edge
//   reset     in  1                  asynchronous active-high reset
//   ReqUpStr  in  NUM_REQ            per-injector request (held until granted)
//   PacketIn  in  NUM_REQ*dataWidth  injector i at [i*dataWidth +: dataWidth]
//   GntUpStr  out NUM_REQ            one-hot, one-cycle grant to the winner
//   UpStrFull out NUM_REQ            router full state mirrored to every injector
//   ReqDnStr  out 1                  request to the router Local port
//   GntDnStr  in  1                  grant from the router Local port
//   DnStrFull in  1                  router Local FIFO full
//   PacketOut out dataWidth          latched winning packet
//   PktCount  out 16                 packets granted by the router since reset (wraps)
module injection_arbiter
    import noc_inj_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int dataWidth = DATA_W_DEF,
    parameter int SEL_W     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             ReqUpStr,
    input  logic [NUM_REQ*dataWidth-1:0]   PacketIn,
    output logic [NUM_REQ-1:0]             GntUpStr,
    output logic [NUM_REQ-1:0]             UpStrFull,
    output logic                           ReqDnStr,
    input  logic                           GntDnStr,
    input  logic                           DnStrFull,
    output logic [dataWidth-1:0]           PacketOut,
    output logic [PKT_CNT_W-1:0]           PktCount
);

    inj_state_e             state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SEL_W-1:0]       last_q, last_d;
    logic [dataWidth-1:0]   pkt_q, pkt_d;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic                   req_dn_q, req_dn_d;
    logic [NUM_REQ-1:0]     gnt_up_q, gnt_up_d;

    logic                   arb_valid;
    logic [SEL_W-1:0]       arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_arbiter (
        .req_i         (ReqUpStr),
        .last_i        (last_q),
        .grant_valid_o (arb_valid),
        .grant_idx_o   (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        pkt_d     = pkt_q;
        pkt_cnt_d = pkt_cnt_q;
        req_dn_d  = req_dn_q;
        gnt_up_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                // A full router blocks arbitration entirely, so last is kept.
                if (arb_valid && !DnStrFull) begin
                    sel_d    = arb_idx;
                    last_d   = arb_idx;
                    pkt_d    = PacketIn[arb_idx*dataWidth +: dataWidth];
                    req_dn_d = 1'b1;
                    state_d  = ST_FWD_REQ;
                end
            end
            ST_FWD_REQ: begin
                // Once issued, the request is held regardless of DnStrFull or
                // the injector withdrawing: the latched packet must go out.
                if (GntDnStr) begin
                    req_dn_d         = 1'b0;
                    gnt_up_d[sel_q]  = 1'b1;
                    pkt_cnt_d        = pkt_cnt_q + 1'b1;
                    state_d          = ST_UP_GNT;
                end
            end
            ST_UP_GNT: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Hold off until the served injector drops its request so the
                // same request is not arbitrated twice.
                if (!ReqUpStr[sel_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            last_q    <= SEL_W'(NUM_REQ - 1);
            pkt_q     <= '0;
            pkt_cnt_q <= '0;
            req_dn_q  <= 1'b0;
            gnt_up_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            pkt_q     <= pkt_d;
            pkt_cnt_q <= pkt_cnt_d;
            req_dn_q  <= req_dn_d;
            gnt_up_q  <= gnt_up_d;
        end
    end

    assign GntUpStr  = gnt_up_q;
    assign UpStrFull = {NUM_REQ{DnStrFull}};
    assign ReqDnStr  = req_dn_q;
    assign PacketOut = pkt_q;
    assign PktCount  = pkt_cnt_q;

endmodule

// File: tb/tb_injection_arbiter.sv
module tb_injection_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   ReqUpStr;
    logic [127:0] PacketIn;
    logic [3:0]   GntUpStr;
    logic [3:0]   UpStrFull;
    logic         ReqDnStr;
    logic         GntDnStr;
    logic         DnStrFull;
    logic [31:0]  PacketOut;
    logic [15:0]  PktCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] pkt [4];

    injection_arbiter #(
        .NUM_REQ   (4),
        .dataWidth (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqUpStr  (ReqUpStr),
        .PacketIn  (PacketIn),
        .GntUpStr  (GntUpStr),
        .UpStrFull (UpStrFull),
        .ReqDnStr  (ReqDnStr),
        .GntDnStr  (GntDnStr),
        .DnStrFull (DnStrFull),
        .PacketOut (PacketOut),
        .PktCount  (PktCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the router request, optionally hold off the router
    // grant for extra cycles, grant, and let the winner drop its request.
    task automatic serve(input string tag, input logic [3:0] exp_gnt,
                         input logic [31:0] exp_pkt, input logic [15:0] exp_cnt,
                         input int hold);
        int n = 0;
        while (!ReqDnStr && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_reqdn"}, {31'd0, ReqDnStr}, 32'd1);
        chk({tag, "_pkt"}, PacketOut, exp_pkt);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, "_hold"}, {31'd0, ReqDnStr}, 32'd1);
        end
        chk({tag, "_pkt_stable"}, PacketOut, exp_pkt);
        GntDnStr = 1'b1;
        tick();
        chk({tag, "_gnt"}, {28'd0, GntUpStr}, {28'd0, exp_gnt});
        chk({tag, "_reqdn_low"}, {31'd0, ReqDnStr}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, PktCount}, {16'd0, exp_cnt});
        $display("pkt %s: gnt=%b pkt=%h cnt=%0d", tag, GntUpStr, PacketOut, PktCount);
        GntDnStr = 1'b0;
        ReqUpStr = ReqUpStr & ~exp_gnt;
        tick();
        chk({tag, "_gnt_pulse"}, {28'd0, GntUpStr}, 32'd0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pkt[i] = 32'hA5A5_0000 | i;
        PacketIn  = {pkt[3], pkt[2], pkt[1], pkt[0]};
        reset     = 1'b1;
        ReqUpStr  = '0;
        GntDnStr  = 1'b0;
        DnStrFull = 1'b0;
        tick();
        tick();
        chk("rst_reqdn", {31'd0, ReqDnStr}, 32'd0);
        chk("rst_gnt", {28'd0, GntUpStr}, 32'd0);
        chk("rst_pkt", PacketOut, 32'd0);
        chk("rst_cnt", {16'd0, PktCount}, 32'd0);
        chk("rst_full", {28'd0, UpStrFull}, 32'd0);
        reset = 1'b0;

        // Single injector, router grants 3 cycles after the request.
        ReqUpStr = 4'b0100;
        serve("single", 4'b0100, 32'hA5A5_0002, 16'd1, 2);

        // Reset in the middle of FWD_REQ (injector 1 in flight).
        ReqUpStr = 4'b0010;
        tick();
        chk("mid_reqdn", {31'd0, ReqDnStr}, 32'd1);
        chk("mid_pkt", PacketOut, pkt[1]);
        tick();
        reset = 1'b1;
        #1;
        chk("arst_reqdn", {31'd0, ReqDnStr}, 32'd0);
        chk("arst_pkt", PacketOut, 32'd0);
        chk("arst_cnt", {16'd0, PktCount}, 32'd0);
        chk("arst_gnt", {28'd0, GntUpStr}, 32'd0);
        tick();
        reset = 1'b0;

        // Fairness: all four request continuously; order must be 0,1,2,3,0,1.
        ReqUpStr = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            serve("fair", 4'b0001 << (n % 4), pkt[n % 4], 16'(n + 1), 0);
            ReqUpStr = 4'b1111;
        end
        ReqUpStr = 4'b0000;
        tick();
        tick();
        tick();

        // Withdrawal during FWD_REQ; injector 3 probes the return to IDLE.
        ReqUpStr = 4'b0001;
        tick();
        chk("wd_reqdn", {31'd0, ReqDnStr}, 32'd1);
        chk("wd_pkt", PacketOut, pkt[0]);
        ReqUpStr  = 4'b1000;
        DnStrFull = 1'b1;
        tick();
        chk("wd_full_hold", {31'd0, ReqDnStr}, 32'd1);
        DnStrFull = 1'b0;
        GntDnStr  = 1'b1;
        tick();
        chk("wd_gnt", {28'd0, GntUpStr}, 32'd1);
        chk("wd_pkt_kept", PacketOut, pkt[0]);
        chk("wd_cnt", {16'd0, PktCount}, 32'd7);
        $display("pkt withdraw: gnt=%b pkt=%h cnt=%0d", GntUpStr, PacketOut, PktCount);
        GntDnStr = 1'b0;
        tick();
        chk("wd_g1_reqdn", {31'd0, ReqDnStr}, 32'd0);
        chk("wd_g1_gnt", {28'd0, GntUpStr}, 32'd0);
        tick();
        chk("wd_g2_reqdn", {31'd0, ReqDnStr}, 32'd0);
        tick();
        chk("wd_g3_reqdn", {31'd0, ReqDnStr}, 32'd1);
        serve("probe3", 4'b1000, pkt[3], 16'd8, 0);

        // Router full blocks arbitration; after release injector 1 wins.
        ReqUpStr  = 4'b1010;
        DnStrFull = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("full_reqdn", {31'd0, ReqDnStr}, 32'd0);
            chk("full_upfull", {28'd0, UpStrFull}, 32'hF);
        end
        DnStrFull = 1'b0;
        #1;
        chk("full_upfull_clr", {28'd0, UpStrFull}, 32'd0);
        serve("full1", 4'b0010, pkt[1], 16'd9, 0);
        serve("full3", 4'b1000, pkt[3], 16'd10, 0);

        // Counter wrap: preload near the top, then two packets.
        force dut.pkt_cnt_q = 16'hFFFE;
        tick();
        release dut.pkt_cnt_q;
        tick();
        chk("wrap_preload", {16'd0, PktCount}, 32'h0000_FFFE);
        ReqUpStr = 4'b0001;
        serve("wrap0", 4'b0001, pkt[0], 16'hFFFF, 0);
        ReqUpStr = 4'b0010;
        serve("wrap1", 4'b0010, pkt[1], 16'h0000, 1);
        tick();
        chk("wrap_stay", {16'd0, PktCount}, 32'd0);
        chk("wrap_reqdn", {31'd0, ReqDnStr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
